// File: rtl/warp_pkg.sv
// Shared integer-pipeline constants for the writeback arbiter and its neighbours.
package warp_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned NUM_XREGS      = 32;
  localparam int unsigned XREG_ADDR_W    = 5;
  localparam int unsigned WB_UNIT_XARITH = 0;
  localparam int unsigned WB_UNIT_XLOGIC = 1;

  // One-hot register release mask; x0 never releases a scoreboard bit.
  function automatic logic [NUM_XREGS-1:0] rd_onehot(input logic [XREG_ADDR_W-1:0] rd);
    rd_onehot = (rd == '0) ? '0 : (NUM_XREGS'(1) << rd);
  endfunction

endpackage

// File: rtl/warp_wb_rr_pick.sv
// Round-robin picker: first requester at or after ptr that is not excluded.
module warp_wb_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     excl,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [N-1:0] avail;

  assign avail = req & ~excl;

  always_comb begin
    int unsigned j;
    j       = 0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr) + i) % N;
      if (!found_c && avail[IDX_W'(j)]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/warp_writeback.sv
// Writeback arbiter: grants up to two unit results per cycle onto the two
// register-file write ports, round-robin, never targeting the same register twice.
module warp_writeback #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned XLEN      = 64
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_UNITS-1:0]                 i_unit_valid,
  output logic [NUM_UNITS-1:0]                 o_unit_ready,
  input  logic [5*NUM_UNITS-1:0]               i_unit_rd,
  input  logic [XLEN*NUM_UNITS-1:0]            i_unit_result,
  output logic                                 o_rd1_wen,
  output logic [warp_pkg::XREG_ADDR_W-1:0]     o_rd1_addr,
  output logic [XLEN-1:0]                      o_rd1_wdata,
  output logic                                 o_rd2_wen,
  output logic [warp_pkg::XREG_ADDR_W-1:0]     o_rd2_addr,
  output logic [XLEN-1:0]                      o_rd2_wdata,
  output logic [warp_pkg::NUM_XREGS-1:0]       o_retire0,
  output logic [warp_pkg::NUM_XREGS-1:0]       o_retire1
);

  import warp_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_UNITS);

  logic [XREG_ADDR_W-1:0] unit_rd  [NUM_UNITS];
  logic [XLEN-1:0]        unit_res [NUM_UNITS];

  logic [IDX_W-1:0]     ptr, ptr_next;
  logic                 found_a, found_b;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic [NUM_UNITS-1:0] excl_b;
  logic [XREG_ADDR_W-1:0] rd_a, rd_b;
  logic [XLEN-1:0]      res_a, res_b;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx == IDX_W'(NUM_UNITS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      unit_rd[k]  = i_unit_rd[5*k +: 5];
      unit_res[k] = i_unit_result[XLEN*k +: XLEN];
    end
  end

  warp_wb_rr_pick #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_pick_a (
    .req     (i_unit_valid),
    .excl    ({NUM_UNITS{1'b0}}),
    .ptr     (ptr),
    .found_c (found_a),
    .idx_c   (idx_a)
  );

  assign rd_a  = unit_rd[idx_a];
  assign res_a = unit_res[idx_a];

  // B may not be A itself nor any unit sharing A's nonzero destination.
  always_comb begin
    excl_b = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      excl_b[k] = (found_a && (idx_a == IDX_W'(k))) ||
                  ((rd_a != '0) && (unit_rd[k] == rd_a));
    end
  end

  warp_wb_rr_pick #(.N(NUM_UNITS), .IDX_W(IDX_W)) u_pick_b (
    .req     (i_unit_valid),
    .excl    (excl_b),
    .ptr     (ptr),
    .found_c (found_b),
    .idx_c   (idx_b)
  );

  assign rd_b  = unit_rd[idx_b];
  assign res_b = unit_res[idx_b];

  always_comb begin
    o_unit_ready = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      o_unit_ready[k] = i_rst_n &&
                        ((found_a && (idx_a == IDX_W'(k))) ||
                         (found_b && (idx_b == IDX_W'(k))));
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (found_b) begin
      ptr_next = next_idx(idx_b);
    end else if (found_a) begin
      ptr_next = next_idx(idx_a);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= '0;
      o_rd1_wen   <= 1'b0;
      o_rd1_addr  <= '0;
      o_rd1_wdata <= '0;
      o_rd2_wen   <= 1'b0;
      o_rd2_addr  <= '0;
      o_rd2_wdata <= '0;
      o_retire0   <= '0;
      o_retire1   <= '0;
    end else begin
      ptr       <= ptr_next;
      o_rd1_wen <= found_a && (rd_a != '0);
      o_rd2_wen <= found_b && (rd_b != '0);
      o_retire0 <= found_a ? rd_onehot(rd_a) : '0;
      o_retire1 <= found_b ? rd_onehot(rd_b) : '0;
      if (found_a) begin
        o_rd1_addr  <= rd_a;
        o_rd1_wdata <= res_a;
      end
      if (found_b) begin
        o_rd2_addr  <= rd_b;
        o_rd2_wdata <= res_b;
      end
    end
  end

endmodule

// File: tb/tb_warp_writeback.sv
// Directed bench for warp_writeback with hand-computed expectations.
module tb_warp_writeback;

  localparam int unsigned NU = 4;
  localparam int unsigned XL = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NU-1:0]     valid;
  logic [NU-1:0]     ready;
  logic [5*NU-1:0]   urd;
  logic [XL*NU-1:0]  ures;
  logic              rd1_wen, rd2_wen;
  logic [4:0]        rd1_addr, rd2_addr;
  logic [XL-1:0]     rd1_wdata, rd2_wdata;
  logic [31:0]       retire0, retire1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  warp_writeback #(.NUM_UNITS(NU), .XLEN(XL)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_unit_valid  (valid),
    .o_unit_ready  (ready),
    .i_unit_rd     (urd),
    .i_unit_result (ures),
    .o_rd1_wen     (rd1_wen),
    .o_rd1_addr    (rd1_addr),
    .o_rd1_wdata   (rd1_wdata),
    .o_rd2_wen     (rd2_wen),
    .o_rd2_addr    (rd2_addr),
    .o_rd2_wdata   (rd2_wdata),
    .o_retire0     (retire0),
    .o_retire1     (retire1)
  );

  task automatic set_unit(input int k, input logic v, input logic [4:0] rd, input logic [XL-1:0] res);
    valid[k]          = v;
    urd[5*k +: 5]     = rd;
    ures[XL*k +: XL]  = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    urd   = '0;
    ures  = '0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '0; urd = '0; ures = '0;
    set_unit(0, 1'b1, 5'd5, 64'h1234);
    #2;
    n_tests++;
    if (ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", ready); end
    n_tests++;
    if ({rd1_wen, rd2_wen, rd1_addr, rd2_addr, rd1_wdata, rd2_wdata, retire0, retire1} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: wen %b%b addr %0d/%0d retire %h/%h", rd1_wen, rd2_wen, rd1_addr, rd2_addr, retire0, retire1);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b want 0001", ready); end
    step();
    valid = '0;
    n_tests++;
    if (rd1_wen !== 1'b1 || rd1_addr !== 5'd5 || rd1_wdata !== 64'h1234 || retire0 !== 32'h20 || rd2_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_write: wen %b addr %0d data %h retire0 %h wen2 %b want 1 5 1234 20 0", rd1_wen, rd1_addr, rd1_wdata, retire0, rd2_wen);
    end
  endtask

  task automatic test_dual();
    do_reset();
    set_unit(0, 1'b1, 5'd3, 64'hA3);
    set_unit(1, 1'b1, 5'd7, 64'hB7);
    #1;
    n_tests++;
    if (ready !== 4'b0011) begin n_fail++; $display("FAIL dual_ready: got %b want 0011", ready); end
    step();
    n_tests++;
    if (rd1_wen !== 1'b1 || rd1_addr !== 5'd3 || rd1_wdata !== 64'hA3 || rd2_wen !== 1'b1 || rd2_addr !== 5'd7 || rd2_wdata !== 64'hB7) begin
      n_fail++; $display("FAIL dual_ports: p1 %b/%0d/%h p2 %b/%0d/%h want 1/3/a3 1/7/b7", rd1_wen, rd1_addr, rd1_wdata, rd2_wen, rd2_addr, rd2_wdata);
    end
    n_tests++;
    if (retire0 !== 32'h8 || retire1 !== 32'h80) begin n_fail++; $display("FAIL dual_retire: got %h/%h want 8/80", retire0, retire1); end
    // ptr should now be 2: unit2 wins A ahead of unit0
    valid = '0;
    set_unit(0, 1'b1, 5'd4, 64'hC4);
    set_unit(2, 1'b1, 5'd6, 64'hD6);
    #1;
    n_tests++;
    if (ready !== 4'b0101) begin n_fail++; $display("FAIL dual_ptr_ready: got %b want 0101", ready); end
    step();
    valid = '0;
    n_tests++;
    if (rd1_addr !== 5'd6 || rd1_wdata !== 64'hD6 || rd2_addr !== 5'd4 || rd2_wdata !== 64'hC4) begin
      n_fail++; $display("FAIL dual_ptr_order: p1 %0d/%h p2 %0d/%h want 6/d6 4/c4", rd1_addr, rd1_wdata, rd2_addr, rd2_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ready;
    int base;
    do_reset();
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 5'(k + 1), 64'h100 + 64'(k));
    for (int c = 0; c < 3; c++) begin
      base      = (c % 2 == 0) ? 0 : 2;
      exp_ready = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      #1;
      n_tests++;
      if (ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, ready, exp_ready); end
      step();
      n_tests++;
      if (rd1_wen !== 1'b1 || rd1_addr !== 5'(base + 1) || rd1_wdata !== 64'h100 + 64'(base) ||
          rd2_wen !== 1'b1 || rd2_addr !== 5'(base + 2) || rd2_wdata !== 64'h101 + 64'(base)) begin
        n_fail++; $display("FAIL b2b_ports[%0d]: p1 %0d/%h p2 %0d/%h want %0d %0d", c, rd1_addr, rd1_wdata, rd2_addr, rd2_wdata, base + 1, base + 2);
      end
    end
    valid = '0;
  endtask

  task automatic test_conflict();
    do_reset();
    set_unit(0, 1'b1, 5'd10, 64'h10);
    step();
    valid = '0;
    set_unit(1, 1'b1, 5'd9, 64'h91);
    set_unit(2, 1'b1, 5'd9, 64'h92);
    #1;
    n_tests++;
    if (ready !== 4'b0010) begin n_fail++; $display("FAIL conflict_ready1: got %b want 0010", ready); end
    step();
    valid[1] = 1'b0;
    n_tests++;
    if (rd1_wen !== 1'b1 || rd1_addr !== 5'd9 || rd1_wdata !== 64'h91 || rd2_wen !== 1'b0 || retire1 !== 32'h0) begin
      n_fail++; $display("FAIL conflict_cycle1: p1 %b/%0d/%h wen2 %b retire1 %h", rd1_wen, rd1_addr, rd1_wdata, rd2_wen, retire1);
    end
    #1;
    n_tests++;
    if (ready !== 4'b0100) begin n_fail++; $display("FAIL conflict_ready2: got %b want 0100", ready); end
    step();
    valid = '0;
    n_tests++;
    if (rd1_wen !== 1'b1 || rd1_addr !== 5'd9 || rd1_wdata !== 64'h92 || rd2_wen !== 1'b0 || retire0 !== 32'h200) begin
      n_fail++; $display("FAIL conflict_cycle2: p1 %b/%0d/%h wen2 %b retire0 %h", rd1_wen, rd1_addr, rd1_wdata, rd2_wen, retire0);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_unit(0, 1'b1, 5'd0, 64'hFFFF);
    #1;
    n_tests++;
    if (ready !== 4'b0001) begin n_fail++; $display("FAIL rd0_ready: got %b want 0001", ready); end
    step();
    valid = '0;
    n_tests++;
    if (rd1_wen !== 1'b0 || retire0 !== 32'h0 || rd2_wen !== 1'b0 || retire1 !== 32'h0) begin
      n_fail++; $display("FAIL rd0_nowrite: wen %b%b retire %h/%h want 00 0/0", rd1_wen, rd2_wen, retire0, retire1);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 4; k++) set_unit(k, 1'b1, 5'(k + 20), 64'h200 + 64'(k));
    step();
    n_tests++;
    if (rd1_wen !== 1'b1 || rd2_wen !== 1'b1 || ready !== 4'b1100) begin
      n_fail++; $display("FAIL mid_prestate: wen %b%b ready %b want 11 1100", rd1_wen, rd2_wen, ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rd1_wen, rd2_wen, rd1_addr, rd2_addr, rd1_wdata, rd2_wdata, retire0, retire1} !== '0 || ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async_clear: wen %b%b retire %h/%h ready %b", rd1_wen, rd2_wen, retire0, retire1, ready);
    end
    step();
    n_tests++;
    if (rd1_wen !== 1'b0 || rd2_wen !== 1'b0 || retire0 !== 32'h0 || retire1 !== 32'h0) begin
      n_fail++; $display("FAIL mid_held: wen %b%b retire %h/%h", rd1_wen, rd2_wen, retire0, retire1);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ready !== 4'b0011) begin n_fail++; $display("FAIL mid_ptr_zero: ready %b want 0011", ready); end
    step();
    valid = '0;
    n_tests++;
    if (rd1_addr !== 5'd20 || rd2_addr !== 5'd21) begin
      n_fail++; $display("FAIL mid_after_release: addr %0d/%0d want 20/21", rd1_addr, rd2_addr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    urd   = '0;
    ures  = '0;
    @(negedge clk);
    test_reset();
    test_dual();
    test_back_to_back();
    test_conflict();
    test_rd_zero();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/warp_writeback.md
Name: warp_writeback

Overview:
- Writeback arbiter between the integer execution units (xarith, xlogic, and future units) and the two write ports of the integer register file.
- Accepts one result per unit via valid/ready and grants up to two results per cycle, round-robin.
- Drives registered rd1/rd2 write-port signals and per-port one-hot retire masks, which go back to issue for scoreboard release.
- Replaces the fixed unit-to-port wiring so that more than two execution units can write back.

Parameters:
- NUM_UNITS, 4, number of execution-unit result channels (2..8); unit 0 = xarith, unit 1 = xlogic.
- XLEN, 64, result data width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_unit_valid  in  NUM_UNITS  per-unit result valid.
- o_unit_ready  out  NUM_UNITS  per-unit grant; result consumed on valid&ready at the rising edge.
- i_unit_rd  in  5*NUM_UNITS  per-unit destination register; unit k at [5k+4:5k].
- i_unit_result  in  XLEN*NUM_UNITS  per-unit result; unit k at [XLEN*k+XLEN-1:XLEN*k].
- o_rd1_wen  out  1  write port 1 enable.
- o_rd1_addr  out  5  write port 1 address.
- o_rd1_wdata  out  XLEN  write port 1 data.
- o_rd2_wen  out  1  write port 2 enable.
- o_rd2_addr  out  5  write port 2 address.
- o_rd2_wdata  out  XLEN  write port 2 data.
- o_retire0  out  32  one-hot rd released by port 1 (to issue i_inst0_retire).
- o_retire1  out  32  one-hot rd released by port 2 (to issue i_inst1_retire).

Behaviour:
- Reset values (asynchronous, immediate on i_rst_n=0):
  - all o_rd*_wen, addr, wdata = 0;
  - o_retire0/1 = 0;
  - round-robin pointer = 0.
- o_unit_ready is combinational and is 0 while in reset.
- Handshake:
  - A unit holds valid, rd and result stable until it sees ready.
  - A unit's valid must not depend combinationally on its ready.
  - ready=1 only in a cycle where valid=1.
- Arbitration (combinational, each cycle):
  - Scan units in order ptr, ptr+1, …, ptr+NUM_UNITS-1, modulo NUM_UNITS.
  - First valid unit = winner A.
  - Next valid unit after A whose rd differs from A's rd, or either rd = 0, = winner B.
  - Grant A, and B if it exists.
- Same-rd conflict: a second unit with the same nonzero rd as A is not granted this cycle and stays pending. This guarantees that both ports never target the same register.
- Pointer update:
  - If B was granted, ptr <= (B+1) mod NUM_UNITS.
  - Else if A was granted, ptr <= (A+1) mod NUM_UNITS.
  - Else ptr is unchanged.
  - Wrap from NUM_UNITS-1 to 0.
- Output register (latency 1 cycle from handshake to write-port assertion):
  - Port 1 <= A's rd and result; o_rd1_wen = (A granted) & (rd≠0).
  - Port 2 <= B's rd and result; o_rd2_wen = (B granted) & (rd≠0).
  - Non-granted port: wen=0; addr/wdata hold their previous values.
- Retire: o_retireN = (1<<rd) when port N granted and rd≠0, else 0. rd=x0 results are consumed with no write and no retire bit.
- Throughput: up to 2 results/cycle sustained; no internal buffering beyond the output register; no backpressure from the register file.
- Starvation freedom: a continuously valid unit is granted within ceil(NUM_UNITS/2) cycles, except when a same-rd conflict blocks it. A blocked unit becomes A as soon as the pointer reaches it.
- Reset mid-operation: pending unit results are dropped (units reset too). Outputs clear that same cycle, with no partial write.

Decomposition:
- Shared package (warp_pkg): XLEN, NUM_XREGS=32, XREG_ADDR_W=5, unit index constants (WB_UNIT_XARITH=0, WB_UNIT_XLOGIC=1).
- Sub-module warp_wb_rr_pick: given a request vector, a pointer and an exclusion mask, returns found flag and index of the first requester at or after the pointer. Instantiated twice: for A, then for B with A and conflicting-rd units masked out.

Test Plan:
- Reset with unit0 valid, rd=5, result=0x1234 -> while i_rst_n=0, ready=0000 and all outputs 0. After release, next edge grants unit0; the following cycle shows rd1_wen=1, rd1_addr=5, wdata=0x1234, o_retire0=0x20, rd2_wen=0.
- Units 0,1 valid (rd 3, 7) at ptr=0 -> ready=0011. Next cycle: port1 rd=3, port2 rd=7, retire0=0x8, retire1=0x80; ptr=2.
- All 4 units continuously valid with distinct rd -> grant sequence {0,1},{2,3},{0,1}. Each unit is granted every 2 cycles; ptr wraps 2→0.
- Units 1,2 both valid with rd=9 at ptr=1 -> cycle 1 grants only unit1 (port1 rd=9, port2 wen=0, ptr=2). Cycle 2 grants unit2 on port1 with rd=9.
- Unit0 valid with rd=0, result=0xFFFF -> ready=0001, consumed. Next cycle: rd1_wen=0, retire0=0.
- Assert i_rst_n=0 mid-stream with 2 grants in flight -> outputs and retire clear asynchronously; ptr=0 after release; no write occurs.
